// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and alignment helper for the memory arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_access_size_t;

  typedef enum logic {
    ARB_PORT_IF = 1'b0,
    ARB_PORT_D  = 1'b1
  } arb_port_t;

  function automatic logic mem_misaligned(input logic [31:0] addr, input mem_access_size_t size);
    return (size == MEM_HALF && addr[0]) || (size == MEM_WORD && addr[1:0] != 2'b00);
  endfunction
endpackage

// File: rtl/mem_if.sv
// mem_if: shared single-port memory bus, combinational read and one-cycle write
interface mem_if;
  import mem_arbiter_pkg::*;
  logic [31:0]      rd_addr;
  mem_access_size_t rd_size;
  logic [31:0]      rd_data;
  logic             wr_enable;
  logic [31:0]      wr_addr;
  mem_access_size_t wr_size;
  logic [31:0]      wr_data;
  modport slave (output rd_addr, rd_size, wr_enable, wr_addr, wr_size, wr_data, input rd_data);
  modport master (input rd_addr, rd_size, wr_enable, wr_addr, wr_size, wr_data, output rd_data);
endinterface

// File: rtl/mem_arb_resp_reg.sv
// mem_arb_resp_reg: per-port response holding register with valid/ready handshake
module mem_arb_resp_reg (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        i_load,
  input  logic [31:0] i_data,
  input  logic        i_err,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [31:0] o_data,
  output logic        o_err
);
  logic        r_valid;
  logic [31:0] r_data;
  logic        r_err;
  // a new grant reloads the response; otherwise a handshake drops valid and data stays put
  always_ff @(posedge clk_i)
    if (!reset_n_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_err   <= i_err;
    end else if (i_ready) r_valid <= 1'b0;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_err   = r_err;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: data-priority arbiter with ifetch starvation guard onto one memory port
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             if_req_valid_i,
  output logic             if_req_ready_o,
  input  logic [31:0]      if_req_addr_i,
  output logic             if_resp_valid_o,
  input  logic             if_resp_ready_i,
  output logic [31:0]      if_resp_data_o,
  output logic             if_resp_err_o,
  input  logic             d_req_valid_i,
  output logic             d_req_ready_o,
  input  logic [31:0]      d_req_addr_i,
  input  mem_access_size_t d_req_size_i,
  input  logic             d_req_write_i,
  input  logic [31:0]      d_req_wdata_i,
  output logic             d_resp_valid_o,
  input  logic             d_resp_ready_i,
  output logic [31:0]      d_resp_data_o,
  output logic             d_resp_err_o,
  mem_if.slave             memif
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] r_starve_cnt;
  logic          w_if_elig, w_d_elig, w_starved, w_if_gnt, w_d_gnt;
  logic          w_if_mis, w_d_mis;
  logic [31:0]   w_if_rdata, w_d_rdata;
  arb_port_t     w_sel;

  assign w_if_elig = if_req_valid_i && (!if_resp_valid_o || if_resp_ready_i);
  assign w_d_elig  = d_req_valid_i && (!d_resp_valid_o || d_resp_ready_i);
  assign w_starved = r_starve_cnt == CW'(STARVE_LIMIT);
  assign w_if_gnt  = reset_n_i && w_if_elig && (!w_d_elig || w_starved);
  assign w_d_gnt   = reset_n_i && w_d_elig && !w_if_gnt;
  assign w_sel     = w_if_gnt ? ARB_PORT_IF : ARB_PORT_D;

  assign if_req_ready_o = w_if_gnt;
  assign d_req_ready_o  = w_d_gnt;

  assign w_if_mis = mem_misaligned(if_req_addr_i, MEM_WORD);
  assign w_d_mis  = mem_misaligned(d_req_addr_i, d_req_size_i);

  assign memif.rd_addr   = !(w_if_gnt || w_d_gnt) ? '0 : (w_sel == ARB_PORT_IF) ? if_req_addr_i : d_req_addr_i;
  assign memif.rd_size   = w_d_gnt ? d_req_size_i : MEM_WORD;
  assign memif.wr_enable = w_d_gnt && d_req_write_i && !w_d_mis;
  assign memif.wr_addr   = d_req_addr_i;
  assign memif.wr_size   = d_req_size_i;
  assign memif.wr_data   = d_req_wdata_i;

  assign w_if_rdata = w_if_mis ? '0 : memif.rd_data;
  assign w_d_rdata  = (d_req_write_i || w_d_mis) ? '0 : memif.rd_data;

  // count data grants that bypass a waiting ifetch; any ifetch grant restarts the count
  always_ff @(posedge clk_i)
    if (!reset_n_i) r_starve_cnt <= '0;
    else if (w_if_gnt) r_starve_cnt <= '0;
    else if (w_d_gnt && w_if_elig) r_starve_cnt <= r_starve_cnt + CW'(1);

  mem_arb_resp_reg u_if_resp (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .i_load    (w_if_gnt),
    .i_data    (w_if_rdata),
    .i_err     (w_if_mis),
    .i_ready   (if_resp_ready_i),
    .o_valid   (if_resp_valid_o),
    .o_data    (if_resp_data_o),
    .o_err     (if_resp_err_o)
  );

  mem_arb_resp_reg u_d_resp (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .i_load    (w_d_gnt),
    .i_data    (w_d_rdata),
    .i_err     (w_d_mis),
    .i_ready   (d_resp_ready_i),
    .o_valid   (d_resp_valid_o),
    .o_data    (d_resp_data_o),
    .o_err     (d_resp_err_o)
  );
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: maximum number of consecutive data grants while ifetch waits.
REQ-002 SHALL have port clk_i, input, 1: sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n_i, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have ports if_req_valid_i (in, 1), if_req_ready_o (out, 1), if_req_addr_i (in, 32): the instruction-fetch request; always a word read.
REQ-005 SHALL have ports if_resp_valid_o (out, 1), if_resp_ready_i (in, 1), if_resp_data_o (out, 32), if_resp_err_o (out, 1): the ifetch response.
REQ-006 SHALL have ports d_req_valid_i (in, 1), d_req_ready_o (out, 1), d_req_addr_i (in, 32), d_req_size_i (in, mem_access_size_t), d_req_write_i (in, 1), d_req_wdata_i (in, 32): the data request.
REQ-007 SHALL have ports d_resp_valid_o (out, 1), d_resp_ready_i (in, 1), d_resp_data_o (out, 32), d_resp_err_o (out, 1): the data response.
REQ-008 SHALL have port memif, mem_if.slave: the shared memory port; drives rd_addr, rd_size, wr_enable, wr_addr, wr_size and wr_data; samples rd_data combinationally.

Function
REQ-009 Each port SHALL have a pending flag (response held); a port is eligible when valid=1 and (pending=0 or a response handshake occurs this cycle).
REQ-010 Grant SHALL be combinational, at most one per cycle; data port wins unless the starvation counter equals STARVE_LIMIT, in which case ifetch wins.
REQ-011 req_ready_o SHALL equal that port's grant; accept = valid & ready at a clock edge; requesters shall not make valid depend on ready.
REQ-012 Starvation counter SHALL increment on a data grant while ifetch is eligible and not granted, clear on any ifetch grant, and hold otherwise; width $clog2(STARVE_LIMIT+1).
REQ-013 In the grant cycle, memif.rd_addr/rd_size SHALL carry the granted address and size (WORD for ifetch); with no grant: rd_addr=0, rd_size=WORD, wr_enable=0.
REQ-014 An aligned data write SHALL assert memif.wr_enable for exactly the grant cycle, with wr_addr, wr_size and wr_data taken from the request; at all other times wr_enable=0.
REQ-015 Misalignment (HALF with addr[0]=1, or WORD with addr[1:0]!=0, on either port) SHALL produce err=1, data=0, and no write.
REQ-016 At the grant edge the port's response register SHALL capture {rd_data, err} for reads, or {0, err} for writes, and set pending; latency is exactly 1 cycle.
REQ-017 resp_valid_o SHALL equal pending; data and err SHALL stay stable until resp_valid & resp_ready, which clears pending unless a new accept occurs at the same edge.
REQ-018 Sustained throughput SHALL be one transaction per cycle on the shared port; a single port with resp_ready=1 SHALL sustain back-to-back accepts.
REQ-019 Reads SHALL pass the full 32-bit address; physical truncation is the memory's responsibility.

Reset
REQ-020 While reset_n_i=0, both req_ready_o SHALL be 0 and memif.wr_enable SHALL be 0, so no request is accepted or written in that cycle.
REQ-021 At a reset edge the following SHALL clear: pending flags and resp_valid_o → 0; resp data → 0; err → 0; starvation counter → 0.
REQ-022 Reset mid-operation SHALL discard held responses without signalling.

Structure
REQ-023 The package definitions SHALL hold mem_access_size_t (existing) and a new arb_port_t {ARB_PORT_IF, ARB_PORT_D}.
REQ-024 The per-port response register SHALL be a sub-module mem_arb_resp_reg, instantiated twice.
REQ-025 The grant logic and starvation counter SHALL reside in mem_arbiter.

Verification
REQ-026 Scenario: ifetch alone reads 0x10 holding 0xDEADBEEF -> ready in the same cycle, resp_valid next cycle, data=0xDEADBEEF, err=0.
REQ-027 Scenario: both ports valid continuously, resp_ready=1, STARVE_LIMIT=4 -> grant pattern D,D,D,D,IF repeating.
REQ-028 Scenario: data HALF write 0xABCD to 0x21 -> err=1, wr_enable never asserts, and a following word read of 0x20 is unchanged.
REQ-029 Scenario: data WORD write 0x11223344 to 0x40, then BYTE read 0x42 -> wr_enable pulses for 1 cycle; the read returns 0x00000022.
REQ-030 Scenario: d_resp_ready=0 for 3 cycles after a read -> resp held stable, d_req_ready=0, ifetch is served meanwhile.
REQ-031 Scenario: reset_n_i=0 in the cycle a write is presented -> no write, all resp_valid=0 after the edge, counter=0.
